gpio_trace_capture: RTL
=======================

# gpio_trace_capture

Synthesizable GPIO output monitor for the MCU SoC timing-validation flow. It samples the 44-bit `gpio_out`/`gpio_oeb` pair every clock, detects any change, and timestamps each change with a free-running cycle counter. Each change becomes a record pushed into an internal FIFO, which drains over a valid/ready stream. This is the capture end of the stimulus-replay path: the replay side drives `gpio_in`, and this block records what the design drives back, so Loom and CVC traces can be diffed record-for-record.

## Interface
Parameters:
- `WIDTH`, 44: GPIO bus width.
- `TS_WIDTH`, 32: timestamp counter width.
- `DEPTH`, 16: record FIFO depth; power of two, ≥ 2.

Ports:
- `clk` in 1: sole clock; all logic is on its rising edge.
- `resetb_l` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: capture enable.
- `clear` in 1: synchronous clear of `overflow` and `drop_count`.
- `gpio_out` in WIDTH: sampled output bus.
- `gpio_oeb` in WIDTH: sampled output-enable bus.
- `rec_valid` out 1: record available.
- `rec_ready` in 1: consumer accepts the record.
- `rec_ts` out TS_WIDTH: timestamp of the record.
- `rec_out` out WIDTH: `gpio_out` value in the record.
- `rec_oeb` out WIDTH: `gpio_oeb` value in the record.
- `rec_baseline` out 1: record is the first sample after `enable` rose.
- `rec_wrapped` out 1: `ts` wrapped since the previous pushed record.
- `overflow` out 1: sticky; a record was dropped.
- `drop_count` out 16: count of dropped records; saturates at 0xFFFF.

## Operation
- **Sample stage.**
  - While `enable`=1, each edge registers `cur = {gpio_oeb, gpio_out}` and `cur_ts = ts`. `ts` increments every edge.
  - While `enable`=0, `ts` holds and no samples are taken.
- **Detect stage.** On the edge after a sample, a push is requested when either:
  - `cur != prev`, or
  - this is the first sample since `enable` rose. That record has `rec_baseline`=1.
  - `prev` updates to `cur` on every sample, whether or not the push succeeds.
- **Wrap flag.**
  - When `ts` rolls from all-ones to 0, an internal `wrap_pend` flag is set.
  - The next pushed record carries `rec_wrapped`=1, and the push clears `wrap_pend`.
  - If a wrap and a push occur in the same cycle, the flag goes to the following record.
- **FIFO.**
  - A push when the FIFO is not full is accepted.
  - A push when the FIFO is full and no pop occurs that cycle is dropped. `overflow` is set and `drop_count` increments (saturating).
  - A push and a pop in the same cycle when full are both accepted; occupancy is unchanged.
  - A dropped record consumes `wrap_pend` and the baseline flag; neither is re-sent.
- **Stream.**
  - `rec_valid` = FIFO not empty. The `rec_*` outputs show the head entry.
  - A pop occurs when `rec_valid && rec_ready`.
  - While `rec_valid`=1 and `rec_ready`=0, the payload holds stable.
- **`clear`.** Zeroes `overflow` and `drop_count`. If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_count`=1.
- **Disable.**
  - `enable` falling stops new samples. A detect already in flight still completes its push.
  - The FIFO keeps draining while disabled.
- **Reset.** Asynchronous assert of `resetb_l`=0 sets `ts`, `prev`, `cur` to 0 and empties the FIFO. Records in flight are lost. After reset the outputs are:
  - `rec_valid`=0,
  - all `rec_*` payload fields = 0,
  - `overflow`=0,
  - `drop_count`=0.

## Timing
- Latency is 2 edges: a change presented before edge N appears with `rec_valid`=1 after edge N+1, given the FIFO was empty.
- `rec_ts` = value of `ts` at edge N.
- The first sample after `enable` rises gets `ts` = held value; the counter continues from there.
- Sustained throughput is one record per cycle. A change every cycle with `rec_ready`=1 never drops.
- `rec_valid` does not combinationally depend on `rec_ready`.
- `rec_ready` feeds only the FIFO pop logic; there is no path from it to the payload outputs.

## Structure
- Package `gpio_trace_pkg` contains:
  - the `trace_rec_t` struct: `ts`, `out`, `oeb`, `baseline`, `wrapped`;
  - the `DROP_CNT_W`=16 constant;
  - the `DROP_MAX` constant.
- Sub-module `trace_fifo`: synchronous FIFO parameterized on payload type and DEPTH.
  - Write pointer, read pointer, and a count each `$clog2(DEPTH)+1` bits wide.
  - Exposes full/empty; supports push and pop in the same cycle.
- The top level holds the sample stage, the detect stage, `ts`, `wrap_pend`, and the overflow/drop logic.

## Test plan
- **Baseline:** reset; `enable`=1 with `gpio_out`=0x0, `gpio_oeb`=0xFFF_FFFF_FFFF held constant; `rec_ready`=1 → exactly one record: `baseline`=1, `ts`=0, matching `out`/`oeb`. No further records for 100 cycles.
- **Single toggle:** in that setup, flip `gpio_out[5]` before edge 10 → a record with `ts`=10 and `out`=0x20, with `rec_valid` rising after edge 11.
- **Overflow:** `DEPTH`=16, `rec_ready`=0, `gpio_out` toggles every cycle for 20 cycles → 16 records stored, `overflow`=1, `drop_count`=4. Then `rec_ready`=1 → 16 records drain with consecutive `ts`.
- **Full with simultaneous push/pop:** FIFO full, one change plus `rec_ready`=1 in the same cycle → no drop, occupancy stays 16.
- **Wrap:** `TS_WIDTH`=4, change every 5 cycles → the first record after `ts` passes 15→0 has `wrapped`=1; all other records have 0.
- **Reset mid-operation:** 8 records queued, `resetb_l` pulsed low for 1 ns → `rec_valid`=0 immediately. After release, `enable`=1 yields a baseline record with `ts`=0.

Source files
------------

// File: rtl/gpio_trace_pkg.sv
// Shared types and constants for the GPIO trace capture block.
// trace_rec_t gives the record layout at the default bus/timestamp widths.
package gpio_trace_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [31:0] ts;
    logic [43:0] out;
    logic [43:0] oeb;
    logic        baseline;
    logic        wrapped;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with push/pop in the same cycle; the head is forced
// to zero while empty so the payload reads as zero after reset.
module trace_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic resetb_l,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q, count_q;
  T            mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when a pop frees the head slot this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge resetb_l) begin
    if (!resetb_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  always_comb begin
    dout_o = '0;
    if (!empty_o) dout_o = mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/gpio_trace_capture.sv
// GPIO output monitor: samples {oeb,out} each enabled cycle, timestamps every
// change and queues it as a record drained over a valid/ready stream.
module gpio_trace_capture
  import gpio_trace_pkg::*;
#(
  parameter int WIDTH    = 44,
  parameter int TS_WIDTH = 32,
  parameter int DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  resetb_l,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      gpio_out,
  input  logic [WIDTH-1:0]      gpio_oeb,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [TS_WIDTH-1:0]   rec_ts,
  output logic [WIDTH-1:0]      rec_out,
  output logic [WIDTH-1:0]      rec_oeb,
  output logic                  rec_baseline,
  output logic                  rec_wrapped,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    out;
    logic [WIDTH-1:0]    oeb;
    logic                baseline;
    logic                wrapped;
  } rec_t;

  logic [TS_WIDTH-1:0]   ts_q, cur_ts_q;
  logic [2*WIDTH-1:0]    cur_q, prev_q;
  logic                  samp_v_q, base_q, armed_q;
  logic                  wrap_pend_q, wrap_pend_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  push_req, pop, drop, wrap_evt, full, empty;
  rec_t                  rec_in, rec_head;

  assign push_req = samp_v_q && (base_q || (cur_q != prev_q));
  assign pop      = !empty && rec_ready;
  assign drop     = push_req && full && !pop;
  assign wrap_evt = enable && (ts_q == '1);

  always_comb begin
    rec_in          = '0;
    rec_in.ts       = cur_ts_q;
    rec_in.out      = cur_q[WIDTH-1:0];
    rec_in.oeb      = cur_q[2*WIDTH-1:WIDTH];
    rec_in.baseline = base_q;
    rec_in.wrapped  = wrap_pend_q;

    // A wrap landing with a push belongs to the next record, not this one.
    wrap_pend_d = wrap_pend_q;
    if (wrap_evt)      wrap_pend_d = 1'b1;
    else if (push_req) wrap_pend_d = 1'b0;

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear)                         drop_cnt_d = DROP_CNT_W'(1);
      else if (drop_cnt_q != DROP_MAX)   drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetb_l) begin
    if (!resetb_l) begin
      ts_q        <= '0;
      cur_ts_q    <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      samp_v_q    <= 1'b0;
      base_q      <= 1'b0;
      armed_q     <= 1'b1;
      wrap_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      samp_v_q <= enable;
      if (enable) begin
        cur_q    <= {gpio_oeb, gpio_out};
        cur_ts_q <= ts_q;
        ts_q     <= ts_q + 1'b1;
        base_q   <= armed_q;
        armed_q  <= 1'b0;
      end else begin
        armed_q  <= 1'b1;
      end
      if (samp_v_q) prev_q <= cur_q;
      wrap_pend_q <= wrap_pend_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetb_l (resetb_l),
    .push_i   (push_req),
    .din_i    (rec_in),
    .pop_i    (rec_ready),
    .dout_o   (rec_head),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign rec_valid    = !empty;
  assign rec_ts       = rec_head.ts;
  assign rec_out      = rec_head.out;
  assign rec_oeb      = rec_head.oeb;
  assign rec_baseline = rec_head.baseline;
  assign rec_wrapped  = rec_head.wrapped;
  assign overflow     = overflow_q;
  assign drop_count   = drop_cnt_q;

endmodule
